asm_layer_seq: RTL and testbench
================================

// Module: asm_layer_seq
// PURPOSE
//  Sequencer for one ASM binary-neuron lane: walks a fully-connected layer,
//  issues pixel/weight/BN SRAM reads, gates pixel data into the lane, drives
//  calculate_en/asm_send/asm_reception, writes each 1-bit result to output SRAM.
//  The lane accumulates every CALCULATE cycle, so this block guarantees zero-value terms on bubbles.
// PARAMETERS
//  IMG_W     16  pixel width (matches lane img_width)
//  BN_W      16  BN threshold width
//  ADDR_W    12  all SRAM address widths; pointers wrap mod 2^ADDR_W
//  CNT_W     10  width of dot-length and output-count config fields
// PORTS
//  clk            in   1       clock
//  rst            in   1       async reset, active low
//  start          in   1       1-cycle pulse; latches cfg_*; ignored unless IDLE
//  hold           in   1       1 = issue no new read this cycle (arbiter backpressure)
//  cfg_dot_len    in   CNT_W   terms per output (0 = empty job)
//  cfg_num_out    in   CNT_W   outputs in job (0 = empty job)
//  cfg_pix_base   in   ADDR_W  pixel vector base
//  cfg_w_base     in   ADDR_W  weight base, row-major [out][term]
//  cfg_bn_base    in   ADDR_W  BN threshold base, one per output
//  cfg_out_base   in   ADDR_W  output feature-map base
//  pix_addr/w_addr/bn_addr  out ADDR_W  SRAM read addresses, read latency 1
//  rd_en          out  1       read strobe for all three SRAMs
//  pix_rdata      in   IMG_W   pixel read data;  w_rdata in 1;  bn_rdata in BN_W
//  asm_pix        out  IMG_W   to lane data_pix: pix_rdata if term valid else 0
//  asm_weight     out  1       to lane data_weights (w_rdata)
//  asm_bn         out  BN_W    to lane data_bn (bn_rdata)
//  calculate_en / asm_send / asm_reception  out 1  lane controls
//  asm_dout       in   1       lane data_out
//  out_wr_en out 1; out_addr out ADDR_W; out_wdata out 1  output SRAM write
//  busy out 1 (state != IDLE);  done out 1 (1-cycle pulse at job end)
// BEHAVIOUR
//  Reset: state IDLE, all outputs/counters 0.  Reset mid-job aborts silently: no done.
//  States: IDLE -start&cfg nonzero-> RUN -last term issued-> DRAIN -last write-> FIN -> IDLE.
//   start with either cfg field 0: IDLE->FIN; done one cycle later, calculate_en never set.
//  Issue stage (RUN, !hold): rd_en=1; pix_addr=pix_base+term; w_addr=running pointer
//   (+1 per issue, no multiplier); bn_addr=bn_base+out. term wraps at dot_len-1, out++.
//  Present stage = issue delayed 1 cycle (valid_p, last_p, out_idx_p) aligned with rdata.
//  asm_pix = valid_p ? pix_rdata : 0 (bubble adds zero). asm_send=asm_reception=valid_p&last_p.
//  Lane toggles ping-pong and loads threshold on send; out_wr_en one cycle after asm_send,
//   out_wdata=asm_dout, out_addr=out_base+out_idx_p (registered). Back-to-back outputs OK.
//  calculate_en: registered, 1 from first issue cycle through last out_wr_en cycle; 0 in FIN.
//  hold during RUN: no issue, counters frozen; present stage keeps draining.
//  dot_len=1: send every valid present cycle.  Threshold compare strict: sum > bn.
//  Latency (no hold): start@0 -> first issue@1 -> first present@2; job of D*N terms issues
//   cycles 1..D*N, last write @D*N+2, done & calculate_en low @D*N+3.
// CONFIGURATION
//  ASM_SEQ_PERF_EN defined: adds outputs perf_cycles[31:0], perf_holds[31:0]; cleared on
//   start, count busy cycles / RUN cycles with hold=1, saturate at max.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  asm_seq_pkg: state enum (IDLE,RUN,DRAIN,FIN), default widths, config struct typedef.
//  Sub-module asm_seq_addr_gen: term/out counters, pixel/weight/bn pointers, last flag.
// TESTING
//  D=3,N=2, pix{5,3,2}, w0{1,1,0}, w1{0,0,1}, bn{4,-7}: writes @5,8 data{1,1}, done @9.
//  Same, bn1=-6 -> out1 = 0 (sum -6 not > -6); addr out_base+0, +1.
//  hold=1 cycles 2-3 -> asm_pix=0 on bubbles, results unchanged, done delayed to 11.
//  cfg_dot_len=0 start@0 -> done @2, no rd_en/calculate_en/out_wr_en ever.
//  start re-pulsed while busy -> ignored; rst low mid-RUN -> all outputs 0 next cycle, no done.
//  D=1,N=4, cfg_w_base=0xFFE -> w_addr 0xFFE,0xFFF,0x000,0x001; 4 consecutive writes.

Source files
------------

// File: rtl/asm_seq_pkg.sv
// Shared widths, FSM state encoding and the latched job descriptor for the
// ASM layer sequencer.
package asm_seq_pkg;

  localparam int IMG_W  = 16;
  localparam int BN_W   = 16;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  dot_len;
    logic [CNT_W-1:0]  num_out;
    logic [ADDR_W-1:0] pix_base;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] bn_base;
    logic [ADDR_W-1:0] out_base;
  } cfg_t;

  function automatic logic cfg_empty(input cfg_t c);
    return (c.dot_len == '0) || (c.num_out == '0);
  endfunction

endpackage

// File: rtl/asm_layer_seq_if.sv
// Job control, SRAM and lane signals of the ASM layer sequencer; the slave
// modport is the sequencer. ASM_SEQ_PERF_EN adds the performance counters.
interface asm_layer_seq_if;
  import asm_seq_pkg::*;

  logic              start;
  logic              hold;
  logic [CNT_W-1:0]  cfg_dot_len;
  logic [CNT_W-1:0]  cfg_num_out;
  logic [ADDR_W-1:0] cfg_pix_base;
  logic [ADDR_W-1:0] cfg_w_base;
  logic [ADDR_W-1:0] cfg_bn_base;
  logic [ADDR_W-1:0] cfg_out_base;
  logic [ADDR_W-1:0] pix_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [ADDR_W-1:0] bn_addr;
  logic              rd_en;
  logic [IMG_W-1:0]  pix_rdata;
  logic              w_rdata;
  logic [BN_W-1:0]   bn_rdata;
  logic [IMG_W-1:0]  asm_pix;
  logic              asm_weight;
  logic [BN_W-1:0]   asm_bn;
  logic              calculate_en;
  logic              asm_send;
  logic              asm_reception;
  logic              asm_dout;
  logic              out_wr_en;
  logic [ADDR_W-1:0] out_addr;
  logic              out_wdata;
  logic              busy;
  logic              done;
`ifdef ASM_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
  logic [31:0]       perf_holds;

  modport slave (
    input  start, hold, cfg_dot_len, cfg_num_out, cfg_pix_base, cfg_w_base,
           cfg_bn_base, cfg_out_base, pix_rdata, w_rdata, bn_rdata, asm_dout,
    output pix_addr, w_addr, bn_addr, rd_en, asm_pix, asm_weight, asm_bn,
           calculate_en, asm_send, asm_reception, out_wr_en, out_addr,
           out_wdata, busy, done, perf_cycles, perf_holds
  );

  modport master (
    output start, hold, cfg_dot_len, cfg_num_out, cfg_pix_base, cfg_w_base,
           cfg_bn_base, cfg_out_base, pix_rdata, w_rdata, bn_rdata, asm_dout,
    input  pix_addr, w_addr, bn_addr, rd_en, asm_pix, asm_weight, asm_bn,
           calculate_en, asm_send, asm_reception, out_wr_en, out_addr,
           out_wdata, busy, done, perf_cycles, perf_holds
  );
`else
  modport slave (
    input  start, hold, cfg_dot_len, cfg_num_out, cfg_pix_base, cfg_w_base,
           cfg_bn_base, cfg_out_base, pix_rdata, w_rdata, bn_rdata, asm_dout,
    output pix_addr, w_addr, bn_addr, rd_en, asm_pix, asm_weight, asm_bn,
           calculate_en, asm_send, asm_reception, out_wr_en, out_addr,
           out_wdata, busy, done
  );

  modport master (
    output start, hold, cfg_dot_len, cfg_num_out, cfg_pix_base, cfg_w_base,
           cfg_bn_base, cfg_out_base, pix_rdata, w_rdata, bn_rdata, asm_dout,
    input  pix_addr, w_addr, bn_addr, rd_en, asm_pix, asm_weight, asm_bn,
           calculate_en, asm_send, asm_reception, out_wr_en, out_addr,
           out_wdata, busy, done
  );
`endif

endinterface

// File: rtl/asm_seq_addr_gen.sv
// Term/output counters and SRAM read pointers; the weight pointer simply
// increments per issue because weights are stored row-major [out][term].
module asm_seq_addr_gen
  import asm_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              advance_i,
  input  cfg_t              cfg_i,
  input  logic [ADDR_W-1:0] w_base_load_i,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [ADDR_W-1:0] bn_addr_o,
  output logic [CNT_W-1:0]  out_idx_o,
  output logic              last_term_o,
  output logic              last_out_o
);

  logic [CNT_W-1:0]  term_q, term_d;
  logic [CNT_W-1:0]  out_q, out_d;
  logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
  logic [CNT_W-1:0]  term_last;
  logic [CNT_W-1:0]  out_last;

  assign term_last   = cfg_i.dot_len - CNT_W'(1);
  assign out_last    = cfg_i.num_out - CNT_W'(1);
  assign last_term_o = (term_q == term_last);
  assign last_out_o  = (out_q == out_last);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    term_d  = term_q;
    out_d   = out_q;
    w_ptr_d = w_ptr_q;
    if (load_i) begin
      term_d  = '0;
      out_d   = '0;
      w_ptr_d = w_base_load_i;
    end else if (advance_i) begin
      w_ptr_d = w_ptr_q + ADDR_W'(1);
      if (last_term_o) begin
        term_d = '0;
        out_d  = out_q + CNT_W'(1);
      end else begin
        term_d = term_q + CNT_W'(1);
      end
    end
  end

  // NOTE: state updates use <= so all flops sample pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      term_q  <= '0;
      out_q   <= '0;
      w_ptr_q <= '0;
    end else begin
      term_q  <= term_d;
      out_q   <= out_d;
      w_ptr_q <= w_ptr_d;
    end
  end

  assign pix_addr_o = cfg_i.pix_base + ADDR_W'(term_q);
  assign w_addr_o   = w_ptr_q;
  assign bn_addr_o  = cfg_i.bn_base + ADDR_W'(out_q);
  assign out_idx_o  = out_q;

endmodule

// File: rtl/asm_layer_seq.sv
// Sequencer for one ASM binary-neuron lane: issues reads, presents gated data
// to the lane, writes results. ASM_SEQ_PERF_EN adds busy/hold cycle counters.
module asm_layer_seq
  import asm_seq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  asm_layer_seq_if.slave bus
);

  cfg_t              cfg_in, cfg_q;
  state_t            state_q;
  logic              accept, issue, send, busy;
  logic              calc_en_q, done_q;
  logic              valid_p_q, last_p_q, final_p_q;
  logic [CNT_W-1:0]  out_idx_p_q;
  logic              wr_en_q, final_w_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [CNT_W-1:0]  out_idx;
  logic              last_term, last_out;

  assign cfg_in = '{dot_len:  bus.cfg_dot_len,  num_out: bus.cfg_num_out,
                    pix_base: bus.cfg_pix_base, w_base:  bus.cfg_w_base,
                    bn_base:  bus.cfg_bn_base,  out_base: bus.cfg_out_base};

  assign accept = (state_q == S_IDLE) && bus.start;
  assign issue  = (state_q == S_RUN) && !bus.hold;
  assign send   = valid_p_q && last_p_q;
  assign busy   = (state_q != S_IDLE);

  asm_seq_addr_gen u_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (accept),
    .advance_i    (issue),
    .cfg_i        (cfg_q),
    .w_base_load_i(bus.cfg_w_base),
    .pix_addr_o   (bus.pix_addr),
    .w_addr_o     (bus.w_addr),
    .bn_addr_o    (bus.bn_addr),
    .out_idx_o    (out_idx),
    .last_term_o  (last_term),
    .last_out_o   (last_out)
  );

  // NOTE: every flop, including the latched job descriptor, is reset so a mid-job reset leaves all outputs at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cfg_q       <= '0;
      calc_en_q   <= 1'b0;
      done_q      <= 1'b0;
      valid_p_q   <= 1'b0;
      last_p_q    <= 1'b0;
      final_p_q   <= 1'b0;
      out_idx_p_q <= '0;
      wr_en_q     <= 1'b0;
      final_w_q   <= 1'b0;
      out_addr_q  <= '0;
    end else begin
      // Present stage mirrors the issue stage one cycle later, matching SRAM latency.
      valid_p_q   <= issue;
      last_p_q    <= last_term;
      final_p_q   <= last_term && last_out;
      out_idx_p_q <= out_idx;
      wr_en_q     <= send;
      final_w_q   <= send && final_p_q;
      if (send) out_addr_q <= cfg_q.out_base + ADDR_W'(out_idx_p_q);
      done_q      <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            cfg_q <= cfg_in;
            if (cfg_empty(cfg_in)) begin
              state_q <= S_FIN;
            end else begin
              state_q   <= S_RUN;
              calc_en_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (issue && last_term && last_out) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (wr_en_q && final_w_q) begin
            state_q   <= S_FIN;
            calc_en_q <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        S_FIN: begin
          // An empty job reaches FIN without done set; it pulses on the way out.
          state_q <= S_IDLE;
          done_q  <= !done_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en         = issue;
  assign bus.asm_pix       = valid_p_q ? bus.pix_rdata : '0;
  assign bus.asm_weight    = valid_p_q && bus.w_rdata;
  assign bus.asm_bn        = valid_p_q ? bus.bn_rdata : '0;
  assign bus.calculate_en  = calc_en_q;
  assign bus.asm_send      = send;
  assign bus.asm_reception = send;
  assign bus.out_wr_en     = wr_en_q;
  assign bus.out_addr      = out_addr_q;
  assign bus.out_wdata     = wr_en_q && bus.asm_dout;
  assign bus.busy          = busy;
  assign bus.done          = done_q;

`ifdef ASM_SEQ_PERF_EN
  logic [31:0] perf_cycles_q, perf_holds_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_holds_q  <= '0;
    end else if (accept) begin
      perf_cycles_q <= '0;
      perf_holds_q  <= '0;
    end else begin
      if (busy && (perf_cycles_q != '1)) perf_cycles_q <= perf_cycles_q + 32'd1;
      if ((state_q == S_RUN) && bus.hold && (perf_holds_q != '1))
        perf_holds_q <= perf_holds_q + 32'd1;
    end
  end

  assign bus.perf_cycles = perf_cycles_q;
  assign bus.perf_holds  = perf_holds_q;
`endif

endmodule

// File: tb/tb_asm_layer_seq.sv
// Randomised bench for asm_layer_seq: SRAM and lane models around the DUT,
// with a dot-product reference model and cycle-level issue expectations.
module tb_asm_layer_seq;
  import asm_seq_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  asm_layer_seq_if bus ();

  asm_layer_seq dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [IMG_W-1:0] pix_mem [0:4095];
  logic             w_mem   [0:4095];
  logic [BN_W-1:0]  bn_mem  [0:4095];

  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.pix_rdata <= pix_mem[bus.pix_addr];
      bus.w_rdata   <= w_mem[bus.w_addr];
      bus.bn_rdata  <= bn_mem[bus.bn_addr];
    end
  end

  // Lane: signed accumulate (+pix for weight 1, -pix for 0), strict compare on send.
  int   lane_acc;
  int   lane_term;
  logic lane_dout;

  always_comb begin
    lane_term = bus.asm_weight ? int'($signed(bus.asm_pix)) : -int'($signed(bus.asm_pix));
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_acc  <= 0;
      lane_dout <= 1'b0;
    end else if (bus.calculate_en) begin
      if (bus.asm_send) begin
        lane_dout <= ((lane_acc + lane_term) > int'($signed(bus.asm_bn)));
        lane_acc  <= 0;
      end else begin
        lane_acc <= lane_acc + lane_term;
      end
    end
  end

  assign bus.asm_dout = lane_dout;

  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int exp_cyc_q[$];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic ref_bit(input int d, input int o, input logic [11:0] pb,
                                   input logic [11:0] wb, input logic [11:0] bb);
    int          sum;
    int          p;
    logic [11:0] a;
    sum = 0;
    for (int t = 0; t < d; t++) begin
      a = pb + 12'(t);
      p = int'($signed(pix_mem[a]));
      a = wb + 12'(o * d + t);
      sum += w_mem[a] ? p : -p;
    end
    a = bb + 12'(o);
    return sum > int'($signed(bn_mem[a]));
  endfunction

  task automatic run_job(input int d, input int n, input logic [11:0] pb,
                         input logic [11:0] wb, input logic [11:0] bb,
                         input logic [11:0] ob, input int hold_mode,
                         input int restart_cyc, output int done_cyc);
    int          tot;
    int          issued;
    int          last_issue;
    int          k;
    int          prev_idx;
    bit          prev_issue;
    bit          h;
    bit          ei;
    logic [11:0] a;
    logic [15:0] exp_pix;
    bit          exp_send;
    tot        = d * n;
    issued     = 0;
    last_issue = -1;
    prev_issue = 0;
    prev_idx   = 0;
    done_cyc   = -1;
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    exp_cyc_q.delete();

    @(posedge clk); #1;
    bus.cfg_dot_len  = CNT_W'(d);
    bus.cfg_num_out  = CNT_W'(n);
    bus.cfg_pix_base = pb;
    bus.cfg_w_base   = wb;
    bus.cfg_bn_base  = bb;
    bus.cfg_out_base = ob;
    bus.start        = 1'b1;
    bus.hold         = 1'b0;
    @(negedge clk);
    check("start_cycle_rd_en", bus.rd_en, 0);

    for (int cyc = 1; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      bus.start = (cyc == restart_cyc);
      if (cyc == restart_cyc) begin
        bus.cfg_dot_len  = CNT_W'(d + 1);
        bus.cfg_num_out  = CNT_W'(n + 1);
        bus.cfg_out_base = ob + 12'h100;
      end
      case (hold_mode)
        1:       h = ($urandom_range(0, 3) == 0);
        2:       h = (cyc == 2) || (cyc == 3);
        default: h = 1'b0;
      endcase
      bus.hold = h;
      @(negedge clk);

      ei = (issued < tot) && !h;
      check("rd_en", bus.rd_en, ei);
      check("calculate_en", bus.calculate_en,
            (tot > 0) && ((last_issue < 0) || (cyc <= last_issue + 2)));
      exp_pix  = '0;
      exp_send = 1'b0;
      if (prev_issue) begin
        a        = pb + 12'(prev_idx % d);
        exp_pix  = pix_mem[a];
        exp_send = ((prev_idx % d) == d - 1);
      end
      check("asm_pix", bus.asm_pix, exp_pix);
      check("asm_send", bus.asm_send, exp_send);
      check("asm_reception", bus.asm_reception, exp_send);

      if (ei) begin
        k = issued;
        a = pb + 12'(k % d);
        check("pix_addr", bus.pix_addr, a);
        a = wb + 12'(k);
        check("w_addr", bus.w_addr, a);
        a = bb + 12'(k / d);
        check("bn_addr", bus.bn_addr, a);
        if ((k % d) == d - 1) exp_cyc_q.push_back(cyc + 2);
        issued++;
        if (issued == tot) last_issue = cyc;
        prev_idx = k;
      end
      prev_issue = ei;

      if (bus.out_wr_en) begin
        wr_addr_q.push_back(int'(bus.out_addr));
        wr_data_q.push_back(int'(bus.out_wdata));
        wr_cyc_q.push_back(cyc);
      end
      if (bus.done) begin
        done_cyc = cyc;
        break;
      end
    end

    check("done_seen", done_cyc >= 0, 1);
    check("done_cycle", done_cyc, (tot > 0) ? last_issue + 3 : 2);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.hold  = 1'b0;
    @(negedge clk);
    check("done_single_pulse", bus.done, 0);
    check("busy_after_done", bus.busy, 0);

    check("n_writes", wr_data_q.size(), (tot > 0) ? n : 0);
    for (int i = 0; i < wr_data_q.size() && i < n && tot > 0; i++) begin
      a = ob + 12'(i);
      check("out_addr", wr_addr_q[i], a);
      check("out_wdata", wr_data_q[i], ref_bit(d, i, pb, wb, bb));
      check("write_cycle", wr_cyc_q[i], exp_cyc_q[i]);
    end
  endtask

  task automatic load_example(input logic [15:0] bn1);
    pix_mem[12'h010] = 16'd5;
    pix_mem[12'h011] = 16'd3;
    pix_mem[12'h012] = 16'd2;
    w_mem[12'h100] = 1'b1; w_mem[12'h101] = 1'b1; w_mem[12'h102] = 1'b0;
    w_mem[12'h103] = 1'b0; w_mem[12'h104] = 1'b0; w_mem[12'h105] = 1'b1;
    bn_mem[12'h200] = 16'd4;
    bn_mem[12'h201] = bn1;
  endtask

  initial begin
    int dc;
    int saw_done;
    int saw_busy;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.hold         = 1'b0;
    bus.cfg_dot_len  = '0;
    bus.cfg_num_out  = '0;
    bus.cfg_pix_base = '0;
    bus.cfg_w_base   = '0;
    bus.cfg_bn_base  = '0;
    bus.cfg_out_base = '0;
    bus.pix_rdata    = 16'hBEEF;
    bus.w_rdata      = 1'b1;
    bus.bn_rdata     = 16'h1234;
    for (int i = 0; i < 4096; i++) begin
      pix_mem[i] = 16'($urandom);
      w_mem[i]   = 1'($urandom);
      bn_mem[i]  = 16'($urandom);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_calc", bus.calculate_en, 0);
    check("rst_wr_en", bus.out_wr_en, 0);
    check("rst_asm_pix", bus.asm_pix, 0);
    check("rst_asm_bn", bus.asm_bn, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Worked example: both outputs fire.
    load_example(16'hFFF9);
    run_job(3, 2, 12'h010, 12'h100, 12'h200, 12'h300, 0, -1, dc);
    check("ex_done", dc, 9);
    check("ex_wdata0", wr_data_q[0], 1);
    check("ex_wdata1", wr_data_q[1], 1);
    check("ex_wcyc0", wr_cyc_q[0], 5);
    check("ex_wcyc1", wr_cyc_q[1], 8);

    // Equality with threshold does not fire.
    load_example(16'hFFFA);
    run_job(3, 2, 12'h010, 12'h100, 12'h200, 12'h300, 0, -1, dc);
    check("eq_wdata0", wr_data_q[0], 1);
    check("eq_wdata1", wr_data_q[1], 0);
    check("eq_addr0", wr_addr_q[0], 12'h300);
    check("eq_addr1", wr_addr_q[1], 12'h301);

    // Hold in cycles 2-3.
    load_example(16'hFFF9);
    run_job(3, 2, 12'h010, 12'h100, 12'h200, 12'h300, 2, -1, dc);
    check("hold_done", dc, 11);
    check("hold_wdata0", wr_data_q[0], 1);
    check("hold_wdata1", wr_data_q[1], 1);

    // Empty jobs.
    run_job(0, 2, 12'h010, 12'h100, 12'h200, 12'h300, 0, -1, dc);
    check("empty_d_done", dc, 2);
    run_job(3, 0, 12'h010, 12'h100, 12'h200, 12'h300, 1, -1, dc);
    check("empty_n_done", dc, 2);

    // start re-pulsed while busy is ignored.
    run_job(3, 2, 12'h010, 12'h100, 12'h200, 12'h300, 0, 3, dc);
    check("restart_done", dc, 9);
    check("restart_wdata1", wr_data_q[1], 1);

    // Weight pointer wrap with back-to-back outputs.
    run_job(1, 4, 12'h020, 12'hFFE, 12'h210, 12'h400, 0, -1, dc);
    check("wrap_done", dc, 7);
    for (int i = 1; i < wr_cyc_q.size(); i++)
      check("wrap_back_to_back", wr_cyc_q[i] - wr_cyc_q[i-1], 1);

    // Reset in the middle of RUN.
    @(posedge clk); #1;
    bus.cfg_dot_len = 10'd4;
    bus.cfg_num_out = 10'd4;
    bus.start       = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rd_en", bus.rd_en, 0);
    check("mid_rst_calc", bus.calculate_en, 0);
    check("mid_rst_asm_pix", bus.asm_pix, 0);
    check("mid_rst_asm_weight", bus.asm_weight, 0);
    check("mid_rst_send", bus.asm_send, 0);
    check("mid_rst_wr_en", bus.out_wr_en, 0);
    check("mid_rst_pix_addr", bus.pix_addr, 0);
    check("mid_rst_w_addr", bus.w_addr, 0);
    @(posedge clk); #1;
    rst_n    = 1'b1;
    saw_done = 0;
    saw_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done++;
      if (bus.busy) saw_busy++;
    end
    check("mid_rst_no_done", saw_done, 0);
    check("mid_rst_stays_idle", saw_busy, 0);

    // Randomised jobs with random backpressure.
    for (int j = 0; j < 25; j++) begin
      int          d;
      int          n;
      logic [11:0] pb, wb, bb, ob;
      for (int i = 0; i < 4096; i++) begin
        pix_mem[i] = 16'($urandom);
        w_mem[i]   = 1'($urandom);
        bn_mem[i]  = 16'($urandom_range(0, 2047)) - 16'd1024;
      end
      d  = $urandom_range(1, 6);
      n  = $urandom_range(1, 5);
      pb = 12'($urandom);
      wb = 12'($urandom);
      bb = 12'($urandom);
      ob = 12'($urandom);
      run_job(d, n, pb, wb, bb, ob, (j % 3 == 0) ? 0 : 1, -1, dc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
